// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, ALU opcodes and bus-source indices for the mini CPU datapath
package cpu_pkg;

  localparam int WORD_W = 32;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SHL  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_ROL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01001;
  localparam logic [4:0] OP_DIV  = 5'b01010;
  localparam logic [4:0] OP_NEG  = 5'b01011;
  localparam logic [4:0] OP_NOT  = 5'b01100;

  // Bus sources; a lower index wins when several drive at once
  localparam int SRC_R0     = 0;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_Y      = 23;
  localparam int NUM_SRC    = 24;

  function automatic logic [63:0] sext64(input logic [WORD_W-1:0] v);
    return {{32{v[WORD_W-1]}}, v};
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational ALU producing a 64-bit result from Y (a) and the bus (b)
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [4:0]        op,
  output logic [63:0]       result
);

  logic [4:0] sh;
  logic [5:0] sh_inv;

  assign sh     = b[4:0];
  assign sh_inv = 6'd32 - {1'b0, sh};

  // Single-word ops zero-extend into the upper half; MUL and DIV fill both halves
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result[31:0] = a + b;
      OP_SUB:  result[31:0] = a - b;
      OP_AND:  result[31:0] = a & b;
      OP_OR:   result[31:0] = a | b;
      OP_SHL:  result[31:0] = a << sh;
      OP_SHR:  result[31:0] = a >> sh;
      OP_SHRA: result[31:0] = $signed(a) >>> sh;
      OP_ROL:  result[31:0] = (a << sh) | (a >> sh_inv);
      OP_ROR:  result[31:0] = (a >> sh) | (a << sh_inv);
      OP_MUL:  result       = sext64(a) * sext64(b);
      OP_DIV: begin
        if (b != '0) begin
          result[31:0]  = $signed(a) / $signed(b);
          result[63:32] = $signed(a) % $signed(b);
        end
      end
      OP_NEG:  result[31:0] = 32'd0 - b;
      OP_NOT:  result[31:0] = ~b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/reg32.sv
// rtl/reg32.sv - 32-bit register with load enable and asynchronous active-low clear
module reg32
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [WORD_W-1:0] d,
  output logic [WORD_W-1:0] q
);

  // Capture d on enabled edges; clear forces zero immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/cpu_data_path.sv
// rtl/cpu_data_path.sv - single-bus 32-bit datapath: register file, special registers, ALU and Z
module cpu_data_path
  import cpu_pkg::*;
(
  input  logic              Clock,
  input  logic              clear,
  input  logic              Read,
  input  logic [4:0]        op,
  input  logic [WORD_W-1:0] Mdatain,
  input  logic R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout,
  input  logic R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic HIin, LOin, ZHighin, Zlowin, IncPC, MDRin, InPortin, Yin,
  output logic [WORD_W-1:0] BusOut,
  output logic [WORD_W-1:0] mdrData,
  output logic [WORD_W-1:0] BusMuxInR0,
  output logic [WORD_W-1:0] BusMuxInR1,
  output logic [WORD_W-1:0] BusMuxInR2,
  output logic [WORD_W-1:0] BusMuxInYOut
);

  logic [15:0]        r_in;
  logic [NUM_SRC-1:0] sel;
  logic [WORD_W-1:0]  src [NUM_SRC];
  logic [WORD_W-1:0]  r_q [16];
  logic [WORD_W-1:0]  hi_q, lo_q, y_q, pc_q, mdr_q, inport_q;
  logic [WORD_W-1:0]  pc_inc, mdr_d;
  logic [63:0]        alu_res, z_q;

  assign r_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                 R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

  assign sel = {Yout, InPortout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout,
                R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_gpr
      reg32 u_r (.clk(Clock), .rst_n(clear), .en(r_in[gi]), .d(BusOut), .q(r_q[gi]));
      assign src[SRC_R0 + gi] = r_q[gi];
    end
  endgenerate

  assign pc_inc = pc_q + 32'd1;
  assign mdr_d  = Read ? Mdatain : BusOut;

  reg32 u_hi     (.clk(Clock), .rst_n(clear), .en(HIin),     .d(BusOut), .q(hi_q));
  reg32 u_lo     (.clk(Clock), .rst_n(clear), .en(LOin),     .d(BusOut), .q(lo_q));
  reg32 u_y      (.clk(Clock), .rst_n(clear), .en(Yin),      .d(BusOut), .q(y_q));
  reg32 u_pc     (.clk(Clock), .rst_n(clear), .en(IncPC),    .d(pc_inc), .q(pc_q));
  reg32 u_mdr    (.clk(Clock), .rst_n(clear), .en(MDRin),    .d(mdr_d),  .q(mdr_q));
  reg32 u_inport (.clk(Clock), .rst_n(clear), .en(InPortin), .d(BusOut), .q(inport_q));

  assign src[SRC_HI]     = hi_q;
  assign src[SRC_LO]     = lo_q;
  assign src[SRC_ZHI]    = z_q[63:32];
  assign src[SRC_ZLO]    = z_q[31:0];
  assign src[SRC_PC]     = pc_q;
  assign src[SRC_MDR]    = mdr_q;
  assign src[SRC_INPORT] = inport_q;
  assign src[SRC_Y]      = y_q;

  // Priority bus mux: scan from the weakest source so the lowest index ends up driving
  always_comb begin
    BusOut = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (sel[i]) BusOut = src[i];
    end
  end

  cpu_alu u_alu (.a(y_q), .b(BusOut), .op(op), .result(alu_res));

  // Z halves load independently from the same-cycle ALU result
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      z_q <= '0;
    end else begin
      if (ZHighin) z_q[63:32] <= alu_res[63:32];
      if (Zlowin)  z_q[31:0]  <= alu_res[31:0];
    end
  end

  assign mdrData      = mdr_q;
  assign BusMuxInR0   = r_q[0];
  assign BusMuxInR1   = r_q[1];
  assign BusMuxInR2   = r_q[2];
  assign BusMuxInYOut = y_q;

endmodule

// File: tb/tb_cpu_data_path.sv
// tb/tb_cpu_data_path.sv - directed self-checking bench for cpu_data_path
module tb_cpu_data_path;

  logic        Clock = 1'b0;
  logic        clear, Read;
  logic [4:0]  op;
  logic [31:0] Mdatain;
  logic R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;
  logic R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out;
  logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout;
  logic R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in;
  logic R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in;
  logic HIin, LOin, ZHighin, Zlowin, IncPC, MDRin, InPortin, Yin;
  logic [31:0] BusOut, mdrData, BusMuxInR0, BusMuxInR1, BusMuxInR2, BusMuxInYOut;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 Clock = ~Clock;

  cpu_data_path dut (
    .Clock(Clock), .clear(clear), .Read(Read), .op(op), .Mdatain(Mdatain),
    .R0out(R0out), .R1out(R1out), .R2out(R2out), .R3out(R3out),
    .R4out(R4out), .R5out(R5out), .R6out(R6out), .R7out(R7out),
    .R8out(R8out), .R9out(R9out), .R10out(R10out), .R11out(R11out),
    .R12out(R12out), .R13out(R13out), .R14out(R14out), .R15out(R15out),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout), .InPortout(InPortout), .Yout(Yout),
    .R0in(R0in), .R1in(R1in), .R2in(R2in), .R3in(R3in),
    .R4in(R4in), .R5in(R5in), .R6in(R6in), .R7in(R7in),
    .R8in(R8in), .R9in(R9in), .R10in(R10in), .R11in(R11in),
    .R12in(R12in), .R13in(R13in), .R14in(R14in), .R15in(R15in),
    .HIin(HIin), .LOin(LOin), .ZHighin(ZHighin), .Zlowin(Zlowin),
    .IncPC(IncPC), .MDRin(MDRin), .InPortin(InPortin), .Yin(Yin),
    .BusOut(BusOut), .mdrData(mdrData), .BusMuxInR0(BusMuxInR0),
    .BusMuxInR1(BusMuxInR1), .BusMuxInR2(BusMuxInR2), .BusMuxInYOut(BusMuxInYOut)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle();
    Read = 0; op = 5'd0; Mdatain = 32'd0;
    {R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out} = '0;
    {R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out} = '0;
    {HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout} = '0;
    {R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in} = '0;
    {R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in} = '0;
    {HIin, LOin, ZHighin, Zlowin, IncPC, MDRin, InPortin, Yin} = '0;
  endtask

  // One clock edge with the current strobes, then drop every strobe
  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Read = 1; MDRin = 1; Mdatain = v; tick();
  endtask

  task automatic set_y(input logic [31:0] v);
    load_mdr(v);
    MDRout = 1; Yin = 1; tick();
  endtask

  // Run op with B taken from MDR, loading both Z halves
  task automatic alu_mdr(input logic [4:0] code, input logic [31:0] b);
    load_mdr(b);
    MDRout = 1; op = code; ZHighin = 1; Zlowin = 1; tick();
  endtask

  task automatic check_z(input string tag, input logic [63:0] exp);
    logic [63:0] z;
    Zhighout = 1; #1; z[63:32] = BusOut;
    Zhighout = 0; Zlowout = 1; #1; z[31:0] = BusOut;
    Zlowout = 0;
    check(tag, z, exp);
  endtask

  task automatic check_pc(input string tag, input logic [31:0] exp);
    PCout = 1; #1;
    check(tag, {32'd0, BusOut}, {32'd0, exp});
    PCout = 0;
  endtask

  initial begin
    idle();
    clear = 0;
    #12;
    check("reset_bus", {32'd0, BusOut}, 64'd0);
    check("reset_mdr", {32'd0, mdrData}, 64'd0);
    check("reset_r2", {32'd0, BusMuxInR2}, 64'd0);
    check("reset_y", {32'd0, BusMuxInYOut}, 64'd0);
    check_z("reset_z", 64'd0);
    @(negedge Clock);
    clear = 1;

    // PC increments from reset
    IncPC = 1; tick();
    IncPC = 1; tick();
    IncPC = 1; tick();
    check_pc("pc_three", 32'd3);

    // Shift sequence
    load_mdr(32'd12);
    check("mdr_load12", {32'd0, mdrData}, 64'd12);
    MDRout = 1; Yin = 1; tick();
    check("y_eq12", {32'd0, BusMuxInYOut}, 64'd12);
    load_mdr(32'd5);
    MDRout = 1; R2in = 1; tick();
    check("r2_eq5", {32'd0, BusMuxInR2}, 64'd5);
    R2out = 1; op = 5'b00100; ZHighin = 1; Zlowin = 1; #1;
    check("shl_bus_b", {32'd0, BusOut}, 64'd5);
    tick();
    check_z("shl_z", 64'h0000_0000_0000_0180);
    Zlowout = 1; R1in = 1; tick();
    check("r1_eq384", {32'd0, BusMuxInR1}, 64'd384);
    Zhighout = 1; R0in = 1; tick();
    check("r0_eq0", {32'd0, BusMuxInR0}, 64'd0);

    // MDR from bus, idle bus
    R2out = 1; MDRin = 1; Read = 0; Mdatain = 32'hDEAD_BEEF; tick();
    check("mdr_from_bus", {32'd0, mdrData}, 64'd5);
    #1;
    check("bus_idle", {32'd0, BusOut}, 64'd0);

    // Priority and load-while-driving
    R1out = 1; MDRout = 1; #1;
    check("prio_r1_over_mdr", {32'd0, BusOut}, 64'd384);
    idle();
    R1out = 1; R2out = 1; R2in = 1; tick();
    check("r2_takes_r1", {32'd0, BusMuxInR2}, 64'd384);

    // Arithmetic
    set_y(32'hFFFF_FFFE);
    alu_mdr(5'b01001, 32'd3);
    check_z("mul_neg2x3", 64'hFFFF_FFFF_FFFF_FFFA);
    set_y(32'hFFFF_FFF9);
    alu_mdr(5'b01010, 32'd2);
    check_z("div_m7_2", 64'hFFFF_FFFF_FFFF_FFFD);
    alu_mdr(5'b01010, 32'd0);
    check_z("div_by0", 64'd0);
    alu_mdr(5'b00001, 32'd2);
    check_z("sub_zext", 64'h0000_0000_FFFF_FFF7);
    alu_mdr(5'b00110, 32'd1);
    check_z("shra_m7", 64'h0000_0000_FFFF_FFFC);
    alu_mdr(5'b00100, 32'd32);
    check_z("shl_by32", 64'h0000_0000_FFFF_FFF9);
    alu_mdr(5'b01000, 32'd4);
    check_z("ror_4", 64'h0000_0000_9FFF_FFFF);
    alu_mdr(5'b01111, 32'd4);
    check_z("bad_op", 64'd0);

    // PC wrap: preload the increment path to reach 0xFFFF_FFFF
    force dut.pc_inc = 32'hFFFF_FFFF;
    IncPC = 1; tick();
    release dut.pc_inc;
    check_pc("pc_max", 32'hFFFF_FFFF);
    IncPC = 1; tick();
    check_pc("pc_wrap", 32'd0);

    // Clear mid-sequence
    load_mdr(32'd5);
    MDRout = 1; R2in = 1; tick();
    set_y(32'd12);
    R2out = 1; op = 5'b00000; ZHighin = 1; Zlowin = 1; tick();
    check_z("add_before_clear", 64'd17);
    IncPC = 1; tick();
    @(negedge Clock);
    clear = 0;
    #1;
    check("clr_r2", {32'd0, BusMuxInR2}, 64'd0);
    check("clr_y", {32'd0, BusMuxInYOut}, 64'd0);
    check("clr_mdr", {32'd0, mdrData}, 64'd0);
    check_z("clr_z", 64'd0);
    check_pc("clr_pc", 32'd0);
    clear = 1;
    load_mdr(32'd7);
    check("after_clear_mdr", {32'd0, mdrData}, 64'd7);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
